// File: rtl/fifo_arb_pkg.sv
// fifo_arb_pkg: shared types, defaults and helpers for the FIFO write arbiter
package fifo_arb_pkg;
  typedef enum logic {IDLE, LOCKED} state_t;
  localparam int DEF_DATA_WIDTH = 15;
  localparam int DEF_FIFO_DEPTH = 16;
  function automatic int clog2_min1(input int n);
    return (n < 2) ? 1 : $clog2(n);
  endfunction
endpackage

// File: rtl/fifo_wr_arbiter_rr_pick.sv
// rr_pick: combinational round-robin priority encoder starting at rr_ptr
module rr_pick import fifo_arb_pkg::*; #(
  parameter int NUM_REQ = 4,
  parameter int IW = clog2_min1(NUM_REQ)
) (
  input  logic [NUM_REQ-1:0] req,
  input  logic [IW-1:0]      rr_ptr,
  output logic               valid,
  output logic [IW-1:0]      idx
);
  logic hi_v, lo_v;
  logic [IW-1:0] hi, lo;
  // lowest requester at or above the pointer wins, else wrap to the lowest below it
  always_comb begin
    hi_v = 1'b0;
    lo_v = 1'b0;
    hi = '0;
    lo = '0;
    for (int i = NUM_REQ - 1; i >= 0; i--) begin
      if (req[i] && i >= int'(rr_ptr)) begin
        hi_v = 1'b1;
        hi = IW'(i);
      end
      if (req[i] && i < int'(rr_ptr)) begin
        lo_v = 1'b1;
        lo = IW'(i);
      end
    end
  end
  assign valid = hi_v | lo_v;
  assign idx = hi_v ? hi : lo;
endmodule

// File: rtl/fifo_wr_arbiter.sv
// fifo_wr_arbiter: round-robin, packet-locking write arbiter with shadow FIFO occupancy
module fifo_wr_arbiter import fifo_arb_pkg::*; #(
  parameter int NUM_REQ = 4,
  parameter int DATA_WIDTH = DEF_DATA_WIDTH,
  parameter int FIFO_DEPTH = DEF_FIFO_DEPTH,
  parameter int CNT_W = $clog2(FIFO_DEPTH + 1),
  localparam int IW = clog2_min1(NUM_REQ)
) (
  input  logic                          clk,
  input  logic                          rst,
  input  logic [NUM_REQ-1:0]            req,
  input  logic [NUM_REQ*DATA_WIDTH-1:0] req_data,
  input  logic [NUM_REQ-1:0]            req_last,
  output logic [NUM_REQ-1:0]            ack,
  input  logic                          rd_req,
  output logic                          fifo_wr_en,
  output logic [DATA_WIDTH-1:0]         fifo_data_in,
  output logic                          fifo_rd_en,
  output logic [CNT_W-1:0]              count,
  output logic                          full,
  output logic                          empty,
  output logic [IW-1:0]                 owner,
  output logic                          locked
);
  state_t state;
  logic [IW-1:0] rr_ptr, pick_idx, cand, nxt_ptr;
  logic pick_valid, cand_valid, accept;
  rr_pick #(.NUM_REQ(NUM_REQ), .IW(IW)) u_pick (
    .req(req),
    .rr_ptr(rr_ptr),
    .valid(pick_valid),
    .idx(pick_idx)
  );
  assign locked = state == LOCKED;
  assign cand = locked ? owner : pick_idx;
  assign cand_valid = locked ? req[owner] : pick_valid;
  assign full = count == CNT_W'(FIFO_DEPTH);
  assign empty = count == '0;
  // the slot is reserved at accept time, so full alone bounds the write side
  assign accept = rst & cand_valid & ~full;
  assign ack = accept ? (NUM_REQ'(1) << cand) : '0;
  assign fifo_rd_en = rd_req & ~empty;
  assign nxt_ptr = (cand == IW'(NUM_REQ - 1)) ? '0 : cand + IW'(1);
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state <= IDLE;
      rr_ptr <= '0;
      owner <= '0;
      count <= '0;
      fifo_wr_en <= 1'b0;
      fifo_data_in <= '0;
    end else begin
      fifo_wr_en <= accept;
      count <= count + CNT_W'(accept) - CNT_W'(fifo_rd_en);
      if (accept) begin
        fifo_data_in <= req_data[cand*DATA_WIDTH +: DATA_WIDTH];
        owner <= cand;
        if (req_last[cand]) begin
          state <= IDLE;
          rr_ptr <= nxt_ptr;
        end else begin
          state <= LOCKED;
        end
      end
    end
  end
endmodule
